// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if
// Bundle between the CHIP-8 memory arbiter, its requesters and BRAM port A.
//   req_*_in      : per-requester request payload (valid/we/lock/addr/data)
//   req_ready_out : one-hot accept back to requesters
//   rsp_*_out     : one-hot read-data-valid pulse + broadcast read data
//   mem_*_out     : registered BRAM port A drive (addra/wea/dina)
//   mem_data_in   : BRAM douta
//   busy_out      : read in flight or lock held
// Modports: slave = arbiter side, master = requester/BRAM side.
interface chip8_mem_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]                 req_valid_in;
  logic [NUM_REQ-1:0]                 req_we_in;
  logic [NUM_REQ-1:0]                 req_lock_in;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]                 req_ready_out;
  logic [NUM_REQ-1:0]                 rsp_valid_out;
  logic [DATA_WIDTH-1:0]              rsp_data_out;
  logic [ADDR_WIDTH-1:0]              mem_addr_out;
  logic                               mem_we_out;
  logic [DATA_WIDTH-1:0]              mem_data_out;
  logic [DATA_WIDTH-1:0]              mem_data_in;
  logic                               busy_out;

  modport slave (
    input  req_valid_in, req_we_in, req_lock_in, req_addr_in, req_data_in, mem_data_in,
    output req_ready_out, rsp_valid_out, rsp_data_out,
           mem_addr_out, mem_we_out, mem_data_out, busy_out
  );

  modport master (
    output req_valid_in, req_we_in, req_lock_in, req_addr_in, req_data_in, mem_data_in,
    input  req_ready_out, rsp_valid_out, rsp_data_out,
           mem_addr_out, mem_we_out, mem_data_out, busy_out
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
// Shares BRAM port A among NUM_REQ requesters (0 = proc, 1 = video, 2 = debug).
// One beat accepted per cycle; the beat is driven to the BRAM on the next
// cycle and read data is routed back to its issuer READ_LATENCY cycles later.
// A requester may hold the grant across beats with req_lock_in.
// Ports:
//   clk_in   : system clock
//   rst_n_in : asynchronous reset, active low
//   bus      : chip8_mem_arbiter_if.slave (request, response, BRAM, busy)
// Build option: define CHIP8_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module chip8_mem_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  chip8_mem_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} lock_state_e;

  lock_state_e                    state;
  logic [IDW-1:0]                 lock_id;
  logic [NUM_REQ-1:0]             elig;
  logic                           gnt_vld;
  logic [IDW-1:0]                 gnt_id;
  logic                           accept;
  logic [READ_LATENCY:0]          vld_pipe;
  logic [READ_LATENCY:0][IDW-1:0] id_pipe;

  // While locked only the lock owner is eligible, even if it is not requesting.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign elig[i] = bus.req_valid_in[i] & ((state == IDLE) | (lock_id == IDW'(i)));
    // Ready is masked by reset so every output reads 0 while held in reset.
    assign bus.req_ready_out[i] = rst_n_in & gnt_vld & (gnt_id == IDW'(i));
    assign bus.rsp_valid_out[i] = vld_pipe[READ_LATENCY] & (id_pipe[READ_LATENCY] == IDW'(i));
  end

`ifdef CHIP8_MEM_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;

  // Search starts one past the last IDLE grant; scanning backwards lets the
  // first eligible index in search order overwrite the later ones.
  always_comb begin
    logic [IDW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + 1 + k) % NUM_REQ);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                       rr_ptr <= IDW'(NUM_REQ - 1);
    else if (accept && (state == IDLE))  rr_ptr <= gnt_id;
  end
`else
  // Fixed priority: backwards scan so the lowest eligible index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(k);
      end
    end
  end
`endif

  assign accept = rst_n_in & gnt_vld;

  // Lock FSM. In LOCKED any accept is necessarily from the owner.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      lock_id <= '0;
    end else begin
      case (state)
        IDLE: if (accept && bus.req_lock_in[gnt_id]) begin
          state   <= LOCKED;
          lock_id <= gnt_id;
        end
        LOCKED: if (accept ? !bus.req_lock_in[lock_id]
                           : (!bus.req_valid_in[lock_id] && !bus.req_lock_in[lock_id]))
          state <= IDLE;
      endcase
    end
  end

  // BRAM drive: addr/data hold when idle, only we drops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.mem_addr_out <= '0;
      bus.mem_we_out   <= 1'b0;
      bus.mem_data_out <= '0;
    end else begin
      bus.mem_we_out <= accept & bus.req_we_in[gnt_id];
      if (accept) begin
        bus.mem_addr_out <= bus.req_addr_in[gnt_id];
        bus.mem_data_out <= bus.req_data_in[gnt_id];
      end
    end
  end

  // Read tracker: stage 0 lines up with the beat on mem_*_out, the last stage
  // with the BRAM data returning.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= accept & ~bus.req_we_in[gnt_id];
      id_pipe[0]  <= gnt_id;
      for (int s = 1; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  assign bus.rsp_data_out = vld_pipe[READ_LATENCY] ? bus.mem_data_in : '0;
  assign bus.busy_out     = (|vld_pipe) | (state == LOCKED);

endmodule
